// File: rtl/intc.sv
// Trap/interrupt sequencer: accepts ecall/ebreak/mret/irq from EX, holds
// the pipeline, writes mepc/mstatus/mcause one per cycle, then redirects.
// Ports: clk, rst (sync, active-high); ex_* from EX; irq_i level irq;
//   csr_*_i current CSR values; csr_intc_* CSR write port; hold_o stall;
//   int_jump_o/int_addr_o one-cycle redirect.
module intc #(
  parameter logic [31:0] CAUSE_ECALL   = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK  = 32'd3,
  parameter logic [31:0] CAUSE_EXT_IRQ = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_ecall_i,
  input  logic        ex_ebreak_i,
  input  logic        ex_mret_i,
  input  logic        irq_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic [11:0] csr_intc_addr_o,
  output logic [31:0] csr_intc_data_o,
  output logic        csr_intc_we_o,
  output logic        hold_o,
  output logic        int_jump_o,
  output logic [31:0] int_addr_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, JUMP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        mret_q, mret_d;

  logic [31:0] ms;
  logic        mie;
  logic        tk_ecall, tk_ebreak, tk_mret, tk_irq;
  logic        unused;

  assign ms     = csr_mstatus_i;
  assign mie    = ms[3];
  assign unused = ^csr_mtvec_i[1:0];

  // Priority-resolved accept requests, only meaningful in IDLE
  assign tk_ecall  = ex_valid_i & ex_ecall_i;
  assign tk_ebreak = ex_valid_i & ~ex_ecall_i & ex_ebreak_i;
  assign tk_mret   = ex_valid_i & ~ex_ecall_i & ~ex_ebreak_i
                   & ex_mret_i;
  assign tk_irq    = ex_valid_i & ~ex_ecall_i & ~ex_ebreak_i
                   & ~ex_mret_i & irq_i & mie;

  always_comb begin
    state_d         = state_q;
    epc_d           = epc_q;
    cause_d         = cause_q;
    mret_d          = mret_q;
    csr_intc_we_o   = 1'b0;
    csr_intc_addr_o = 12'h000;
    csr_intc_data_o = 32'h0;
    hold_o          = 1'b0;
    int_jump_o      = 1'b0;
    int_addr_o      = 32'h0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          tk_ecall: begin
            hold_o  = 1'b1;
            state_d = W_MEPC;
            epc_d   = ex_pc_i;
            cause_d = CAUSE_ECALL;
            mret_d  = 1'b0;
          end
          tk_ebreak: begin
            hold_o  = 1'b1;
            state_d = W_MEPC;
            epc_d   = ex_pc_i;
            cause_d = CAUSE_EBREAK;
            mret_d  = 1'b0;
          end
          tk_mret: begin
            hold_o  = 1'b1;
            state_d = W_MRET;
            mret_d  = 1'b1;
          end
          tk_irq: begin
            hold_o  = 1'b1;
            state_d = W_MEPC;
            epc_d   = ex_pc_i;
            cause_d = CAUSE_EXT_IRQ;
            mret_d  = 1'b0;
          end
          default: ;
        endcase
      end
      W_MEPC: begin
        hold_o          = 1'b1;
        csr_intc_we_o   = 1'b1;
        csr_intc_addr_o = CSR_MEPC;
        csr_intc_data_o = epc_q;
        state_d         = W_MSTATUS;
      end
      W_MSTATUS: begin
        hold_o          = 1'b1;
        csr_intc_we_o   = 1'b1;
        csr_intc_addr_o = CSR_MSTATUS;
        // MPIE <= MIE, MIE <= 0
        csr_intc_data_o = {ms[31:8], ms[3], ms[6:4],
                           1'b0, ms[2:0]};
        state_d         = W_MCAUSE;
      end
      W_MCAUSE: begin
        hold_o          = 1'b1;
        csr_intc_we_o   = 1'b1;
        csr_intc_addr_o = CSR_MCAUSE;
        csr_intc_data_o = cause_q;
        state_d         = JUMP;
      end
      W_MRET: begin
        hold_o          = 1'b1;
        csr_intc_we_o   = 1'b1;
        csr_intc_addr_o = CSR_MSTATUS;
        // MIE <= MPIE, MPIE <= 1
        csr_intc_data_o = {ms[31:8], 1'b1, ms[6:4],
                           ms[7], ms[2:0]};
        state_d         = JUMP;
      end
      JUMP: begin
        hold_o     = 1'b1;
        int_jump_o = 1'b1;
        int_addr_o = mret_q ? csr_mepc_i
                            : {csr_mtvec_i[31:2], 2'b00};
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts the sequence in the same cycle
    if (rst) begin
      csr_intc_we_o   = 1'b0;
      csr_intc_addr_o = 12'h000;
      csr_intc_data_o = 32'h0;
      hold_o          = 1'b0;
      int_jump_o      = 1'b0;
      int_addr_o      = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      epc_q   <= 32'h0;
      cause_q <= 32'h0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

endmodule

// File: tb/tb_intc.sv
// Bench for intc: directed vector table, hand sequences, and random
// stimulus against a queue-based reference model with a CSR file.
module tb_intc;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_ecall_i, ex_ebreak_i, ex_mret_i, irq_i;
  logic [31:0] ex_pc_i;
  logic [31:0] env_ms, env_epc, env_tvec;
  logic [11:0] csr_intc_addr_o;
  logic [31:0] csr_intc_data_o;
  logic        csr_intc_we_o, hold_o, int_jump_o;
  logic [31:0] int_addr_o;

  always #5 clk = ~clk;

  intc dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .ex_ecall_i(ex_ecall_i), .ex_ebreak_i(ex_ebreak_i),
    .ex_mret_i(ex_mret_i), .irq_i(irq_i),
    .csr_mtvec_i(env_tvec), .csr_mepc_i(env_epc),
    .csr_mstatus_i(env_ms),
    .csr_intc_addr_o(csr_intc_addr_o),
    .csr_intc_data_o(csr_intc_data_o),
    .csr_intc_we_o(csr_intc_we_o), .hold_o(hold_o),
    .int_jump_o(int_jump_o), .int_addr_o(int_addr_o)
  );

  int checks = 0;
  int errors = 0;

  logic        pend_we = 1'b0;
  logic [11:0] pend_addr;
  logic [31:0] pend_data;
  logic [31:0] env_mcause;
  logic        sw_en = 1'b0;
  logic [31:0] sw_ms, sw_epc, sw_tvec;

  typedef struct packed {
    logic        h;
    logic        w;
    logic [11:0] a;
    logic [31:0] d;
    logic        j;
    logic [31:0] ja;
  } op_t;

  typedef struct {
    logic        ld;
    logic [31:0] ms, ep;
    logic        r, v, ec, eb, mr, iq;
    logic [31:0] pc;
    op_t         e;
  } vec_t;

  op_t  q[$];
  vec_t tv[$];

  function automatic op_t op(int h, int w, logic [31:0] a,
                             logic [31:0] d, int j,
                             logic [31:0] ja);
    op_t o;
    o.h = (h != 0); o.w = (w != 0); o.a = a[11:0];
    o.d = d; o.j = (j != 0); o.ja = ja;
    return o;
  endfunction

  function automatic vec_t mk(int ld, logic [31:0] ms,
      logic [31:0] ep, int r, int v, int ec, int eb, int mr,
      int iq, logic [31:0] pc, int h, int w, logic [31:0] a,
      logic [31:0] d, int j, logic [31:0] ja);
    vec_t t;
    t.ld = (ld != 0); t.ms = ms; t.ep = ep;
    t.r = (r != 0); t.v = (v != 0); t.ec = (ec != 0);
    t.eb = (eb != 0); t.mr = (mr != 0); t.iq = (iq != 0);
    t.pc = pc;
    t.e = op(h, w, a, d, j, ja);
    return t;
  endfunction

  // One cycle: retire last cycle's CSR write into the CSR file,
  // apply software CSR updates, drive inputs, settle.
  task automatic drive(input logic r, v, ec, eb, mr, iq,
                       input logic [31:0] pc);
    @(negedge clk);
    if (pend_we) begin
      case (pend_addr)
        12'h300: env_ms     = pend_data;
        12'h341: env_epc    = pend_data;
        12'h342: env_mcause = pend_data;
        default: ;
      endcase
    end
    pend_we = 1'b0;
    if (sw_en) begin
      env_ms   = sw_ms;
      env_epc  = sw_epc;
      env_tvec = sw_tvec;
    end
    sw_en = 1'b0;
    rst = r; ex_valid_i = v; ex_ecall_i = ec;
    ex_ebreak_i = eb; ex_mret_i = mr; irq_i = iq;
    ex_pc_i = pc;
    #1;
    pend_we   = csr_intc_we_o;
    pend_addr = csr_intc_addr_o;
    pend_data = csr_intc_data_o;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input op_t e);
    chk({tag, ".hold"}, {31'd0, hold_o}, {31'd0, e.h});
    chk({tag, ".we"}, {31'd0, csr_intc_we_o}, {31'd0, e.w});
    chk({tag, ".addr"}, {20'd0, csr_intc_addr_o}, {20'd0, e.a});
    chk({tag, ".data"}, csr_intc_data_o, e.d);
    chk({tag, ".jump"}, {31'd0, int_jump_o}, {31'd0, e.j});
    chk({tag, ".jaddr"}, int_addr_o, e.ja);
  endtask

  // Reference: an accepted event expands into its list of
  // per-cycle outputs; while the list drains the block is busy.
  task automatic model(input logic r, v, ec, eb, mr, iq,
                       input logic [31:0] pc, output op_t e);
    logic [31:0] cause, tms, mms;
    e = '0;
    if (r) begin
      q.delete();
    end else if (q.size() > 0) begin
      e = q.pop_front();
    end else if (v && (ec || eb || mr || (iq && env_ms[3]))) begin
      e.h = 1'b1;
      tms = (env_ms & ~32'h88) | (env_ms[3] ? 32'h80 : 32'h0);
      mms = (env_ms & ~32'h8) | 32'h80
          | (env_ms[7] ? 32'h8 : 32'h0);
      if (!ec && !eb && mr) begin
        q.push_back(op(1, 1, 32'h300, mms, 0, 0));
        q.push_back(op(1, 0, 0, 0, 1, env_epc));
      end else begin
        cause = ec ? 32'd11 : eb ? 32'd3 : 32'h8000000B;
        q.push_back(op(1, 1, 32'h341, pc, 0, 0));
        q.push_back(op(1, 1, 32'h300, tms, 0, 0));
        q.push_back(op(1, 1, 32'h342, cause, 0, 0));
        q.push_back(op(1, 0, 0, 0, 1, env_tvec & ~32'h3));
      end
    end
  endtask

  initial begin
    op_t e;
    logic r, v, ec, eb, mr, iq;
    logic [31:0] pc;
    int k;
    env_ms = 32'h8; env_epc = 32'h0; env_tvec = 32'h203;
    env_mcause = 32'h0;

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0);
    chk_all("rst0", '0);
    drive(1, 1, 1, 0, 0, 1, 32'h10);
    chk_all("rst1", '0);

    // ecall, mtvec=0x203, mstatus=0x8
    tv.push_back(mk(1,'h8,0, 0,1,1,0,0,0,'h100, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h341,'h100,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h300,'h80,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h342,11,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,0,0,0,1,'h200));
    // irq with MIE=0, then ebreak invalid/valid
    tv.push_back(mk(0,0,0, 0,1,0,0,0,1,'h44, 0,0,0,0,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,1,0,0,'h44, 0,0,0,0,0,0));
    tv.push_back(mk(0,0,0, 0,1,0,1,0,0,'h44, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h341,'h44,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h300,'h0,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h342,3,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,0,0,0,1,'h200));
    // irq with MIE=1
    tv.push_back(mk(1,'h8,0, 0,1,0,0,0,1,'h44, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h341,'h44,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h300,'h80,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0,
                    1,1,'h342,32'h8000000B,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,0,0,0,1,'h200));
    // mret restoring MIE with irq held, irq taken right after
    tv.push_back(mk(1,'h80,'h104, 0,1,0,0,1,1,'h50, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0, 0,1,0,0,0,1,'h54, 1,1,'h300,'h88,0,0));
    tv.push_back(mk(0,0,0, 0,1,0,0,0,1,'h54, 1,0,0,0,1,'h104));
    tv.push_back(mk(0,0,0, 0,1,0,0,0,1,'h60, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h341,'h60,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h300,'h80,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0,
                    1,1,'h342,32'h8000000B,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,0,0,0,1,'h200));
    // ecall and irq together: ecall wins, irq waits for MIE
    tv.push_back(mk(1,'h8,0, 0,1,1,0,0,1,'h70, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h341,'h70,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h300,'h80,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h342,11,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,0,0,0,1,'h200));
    tv.push_back(mk(0,0,0, 0,1,0,0,0,1,'h74, 0,0,0,0,0,0));
    tv.push_back(mk(1,'h88,0, 0,1,0,0,0,1,'h78, 1,0,0,0,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h341,'h78,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,1,'h300,'h80,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0,
                    1,1,'h342,32'h8000000B,0,0));
    tv.push_back(mk(0,0,0, 0,0,0,0,0,0,0, 1,0,0,0,1,'h200));

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].ld) begin
        sw_en = 1'b1; sw_ms = tv[i].ms;
        sw_epc = tv[i].ep; sw_tvec = env_tvec;
      end
      drive(tv[i].r, tv[i].v, tv[i].ec, tv[i].eb, tv[i].mr,
            tv[i].iq, tv[i].pc);
      chk_all($sformatf("tv%0d", i), tv[i].e);
    end

    // irq held 10 cycles with MIE=0 (mstatus=0x80 here)
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 0, 1, 32'h90);
      chk_all($sformatf("mie0_%0d", i), '0);
    end

    // Reset in W_MSTATUS aborts the sequence
    sw_en = 1'b1; sw_ms = 32'h8; sw_epc = env_epc;
    sw_tvec = env_tvec;
    env_mcause = 32'h0;
    drive(0, 1, 1, 0, 0, 0, 32'h200);
    chk_all("ra0", op(1, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_all("ra1", op(1, 1, 32'h341, 32'h200, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0);
    chk_all("ra2", '0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk_all($sformatf("ra_post%0d", i), '0);
    end
    chk("ra.mstatus", env_ms, 32'h8);
    chk("ra.mcause", env_mcause, 32'h0);

    // Random stimulus against the reference model
    for (int n = 0; n < 3000; n++) begin
      if (q.size() == 0 && ($urandom % 6) == 0) begin
        sw_en = 1'b1; sw_ms = $urandom;
        sw_epc = $urandom; sw_tvec = $urandom;
      end
      r  = (($urandom % 150) == 0);
      v  = (($urandom % 4) != 0);
      k  = $urandom % 10;
      ec = (k == 0 || k == 5);
      eb = (k == 1 || k == 5 || k == 6);
      mr = (k == 2 || k == 6 || k == 7);
      iq = (($urandom % 3) == 0);
      pc = $urandom & ~32'h3;
      drive(r, v, ec, eb, mr, iq, pc);
      model(r, v, ec, eb, mr, iq, pc, e);
      chk_all($sformatf("rnd%0d", n), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
